tmds_encoder_mc: RTL and testbench

Multi-channel, pipelined TMDS encoder for the HDMI output path. It is the parametrised successor of the single-channel DVI encoder and adds:
- NUM_CH lanes encoded in lockstep;
- HDMI period modes: video guard band, data-island guard band and TERC4 data island;
- synchronous active-low reset;
- observable per-lane running disparity.

It sits between the video timing/packet mux and the 10:1 serialisers, one instance per link.

---
 rtl/tmds_encoder_mc_if.sv | 14 +
 rtl/tmds_encoder_mc.sv | 128 ++++++++++++
 tb/tb_tmds_encoder_mc.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_mc_if.sv
// rtl/tmds_encoder_mc_if.sv - period/data inputs and symbol/disparity outputs of the TMDS encoder
interface tmds_encoder_mc_if #(
   parameter int NUM_CH = 3
);
   logic [2:0]          mode;
   logic [8*NUM_CH-1:0] vd;
   logic [2*NUM_CH-1:0] cd;
   logic [4*NUM_CH-1:0] ad;
   logic [10*NUM_CH-1:0] tmds;
   logic [5*NUM_CH-1:0] disp;

   modport master (output mode, vd, cd, ad, input tmds, disp);
   modport slave  (input mode, vd, cd, ad, output tmds, disp);
endinterface

// File: rtl/tmds_encoder_mc.sv
// rtl/tmds_encoder_mc.sv - NUM_CH-lane two-stage TMDS/TERC4 encoder with HDMI guard bands
// Stage 1 builds the transition-minimised byte; stage 2 picks the symbol by period and tracks disparity.
module tmds_encoder_mc #(
   parameter int NUM_CH = 3
) (
   input logic              clk,
   input logic              rst_n,
   tmds_encoder_mc_if.slave bus
);
   localparam logic [9:0] CTRL00 = 10'b1101010100;
   localparam logic [9:0] GB_A   = 10'b1011001100;
   localparam logic [9:0] GB_B   = 10'b0100110011;

   function automatic logic [9:0] terc4(input logic [3:0] a);
      case (a)
         4'd0:    terc4 = 10'b1010011100;
         4'd1:    terc4 = 10'b1001100011;
         4'd2:    terc4 = 10'b1011100100;
         4'd3:    terc4 = 10'b1011100010;
         4'd4:    terc4 = 10'b0101110001;
         4'd5:    terc4 = 10'b0100011110;
         4'd6:    terc4 = 10'b0110001110;
         4'd7:    terc4 = 10'b0100111100;
         4'd8:    terc4 = 10'b1011001100;
         4'd9:    terc4 = 10'b0100111001;
         4'd10:   terc4 = 10'b0110011100;
         4'd11:   terc4 = 10'b1011000110;
         4'd12:   terc4 = 10'b1010001110;
         4'd13:   terc4 = 10'b1001110001;
         4'd14:   terc4 = 10'b0101100011;
         default: terc4 = 10'b1011000011;
      endcase
   endfunction

   function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
      case (c)
         2'b00:   ctrl_sym = 10'b1101010100;
         2'b01:   ctrl_sym = 10'b0010101011;
         2'b10:   ctrl_sym = 10'b0101010100;
         default: ctrl_sym = 10'b1010101011;
      endcase
   endfunction

   // Period select travels with the data so stage 2 never mixes modes.
   logic [2:0] mode_q;

   always_ff @(posedge clk) begin
      if (!rst_n) mode_q <= 3'd0;
      else        mode_q <= bus.mode;
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [7:0]        vd_k;
      logic [8:0]        qm_d, qm_q;
      logic [3:0]        n1_d, n1_q;
      logic [1:0]        cd_q;
      logic [3:0]        ad_q;
      logic [9:0]        tmds_d, tmds_q;
      logic signed [4:0] cnt_d, cnt_q;
      logic signed [4:0] diff;
      logic              q8;

      assign vd_k = bus.vd[8*k +: 8];

      always_comb begin
         logic [3:0] pop;
         logic       use_xnor;
         pop = 4'd0;
         for (int i = 0; i < 8; i++) pop = pop + {3'b000, vd_k[i]};
         use_xnor = (pop > 4'd4) || (pop == 4'd4 && !vd_k[0]);
         qm_d = 9'd0;
         qm_d[0] = vd_k[0];
         for (int i = 1; i < 8; i++)
            qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ vd_k[i]) : (qm_d[i-1] ^ vd_k[i]);
         qm_d[8] = ~use_xnor;
         n1_d = 4'd0;
         for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, qm_d[i]};
      end

      // diff = N1 - N0 = 2*N1 - 8, range -8..+8
      assign diff = $signed({n1_q, 1'b0} - 5'd8);
      assign q8   = qm_q[8];

      always_comb begin
         tmds_d = ctrl_sym(cd_q);
         cnt_d  = 5'sd0;
         case (mode_q)
            3'd1: begin
               if (cnt_q == 5'sd0 || n1_q == 4'd4) begin
                  tmds_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
                  cnt_d  = q8 ? cnt_q + diff : cnt_q - diff;
               end else if ((cnt_q > 5'sd0 && n1_q > 4'd4) || (cnt_q < 5'sd0 && n1_q < 4'd4)) begin
                  tmds_d = {1'b1, q8, ~qm_q[7:0]};
                  cnt_d  = cnt_q + (q8 ? 5'sd2 : 5'sd0) - diff;
               end else begin
                  tmds_d = {1'b0, q8, qm_q[7:0]};
                  cnt_d  = cnt_q - (q8 ? 5'sd0 : 5'sd2) + diff;
               end
            end
            3'd2:    tmds_d = (k % 3 == 1) ? GB_B : GB_A;
            3'd3:    tmds_d = (k % 3 == 0) ? terc4({2'b11, cd_q}) : GB_B;
            3'd4:    tmds_d = terc4(ad_q);
            default: tmds_d = ctrl_sym(cd_q);
         endcase
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            qm_q   <= 9'd0;
            n1_q   <= 4'd0;
            cd_q   <= 2'b00;
            ad_q   <= 4'd0;
            tmds_q <= CTRL00;
            cnt_q  <= 5'sd0;
         end else begin
            qm_q   <= qm_d;
            n1_q   <= n1_d;
            cd_q   <= bus.cd[2*k +: 2];
            ad_q   <= bus.ad[4*k +: 4];
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
         end
      end

      assign bus.tmds[10*k +: 10] = tmds_q;
      assign bus.disp[5*k +: 5]   = cnt_q;
   end
endmodule

// File: tb/tb_tmds_encoder_mc.sv
// tb/tb_tmds_encoder_mc.sv - directed checks of the TMDS encoder with 3 and 4 lanes
module tb_tmds_encoder_mc;
   localparam logic [9:0] CTRL00 = 10'b1101010100;
   localparam logic [9:0] CTRL01 = 10'b0010101011;
   localparam logic [9:0] CTRL11 = 10'b1010101011;
   localparam logic [9:0] GB_A   = 10'b1011001100;
   localparam logic [9:0] GB_B   = 10'b0100110011;
   localparam logic [9:0] TERC [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   tmds_encoder_mc_if #(.NUM_CH(3)) bus ();
   tmds_encoder_mc_if #(.NUM_CH(4)) bus4 ();

   tmds_encoder_mc #(.NUM_CH(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   tmds_encoder_mc #(.NUM_CH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   // Lane 3 of the 4-lane instance mirrors lane 0 of the 3-lane instance.
   assign bus4.mode = bus.mode;
   assign bus4.vd   = {bus.vd[7:0], bus.vd};
   assign bus4.cd   = {bus.cd[1:0], bus.cd};
   assign bus4.ad   = {bus.ad[3:0], bus.ad};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] m, input logic [23:0] v,
                        input logic [5:0] c, input logic [11:0] a);
      bus.mode = m;
      bus.vd   = v;
      bus.cd   = c;
      bus.ad   = a;
   endtask

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] d3(input int a2, input int a1, input int a0);
      return {5'(a2), 5'(a1), 5'(a0)};
   endfunction

   initial begin
      drive(3'($urandom), 24'($urandom), 6'($urandom), 12'($urandom));
      step();
      drive(3'd1, 24'($urandom), 6'($urandom), 12'($urandom));
      step();
      step();
      chk("reset_tmds", 40'(bus.tmds), 40'({3{CTRL00}}));
      chk("reset_disp", 40'(bus.disp), 40'(d3(0, 0, 0)));

      rst_n = 1'b1;
      drive(3'd0, 24'($urandom), {3{2'b01}}, 12'($urandom));
      step();
      chk("release_first", 40'(bus.tmds), 40'({3{CTRL00}}));
      step();
      chk("release_ctrl01", 40'(bus.tmds), 40'({3{CTRL01}}));

      // lanes: 0x00, 0xFF, 0x55
      drive(3'd1, {8'h55, 8'hFF, 8'h00}, 6'd0, 12'd0);
      step();
      step();
      chk("vid_s1", 40'(bus.tmds), 40'({10'b0100110011, 10'b1000000000, 10'b0100000000}));
      chk("vid_s1_disp", 40'(bus.disp), 40'(d3(0, -8, -8)));
      step();
      chk("vid_s2", 40'(bus.tmds), 40'({10'b0100110011, 10'b0011111111, 10'b1111111111}));
      chk("vid_s2_disp", 40'(bus.disp), 40'(d3(0, -2, 2)));
      step();
      chk("vid_s3", 40'(bus.tmds), 40'({10'b0100110011, 10'b0011111111, 10'b0100000000}));
      chk("vid_s3_disp", 40'(bus.disp), 40'(d3(0, 4, -6)));
      step();
      chk("vid_s4", 40'(bus.tmds), 40'({10'b0100110011, 10'b1000000000, 10'b1111111111}));
      chk("vid_s4_disp", 40'(bus.disp), 40'(d3(0, -4, 4)));

      drive(3'd0, 24'd0, 6'd0, 12'd0);
      step();
      step();
      chk("ctrl_disp_clear", 40'(bus.disp), 40'(d3(0, 0, 0)));

      drive(3'd1, {3{8'hFF}}, 6'd0, 12'd0);
      step();
      step();
      chk("hop_a", 40'(bus.tmds), 40'({3{10'b1000000000}}));
      chk("hop_a_disp", 40'(bus.disp), 40'(d3(-8, -8, -8)));
      chk("hop_a_lane3", 40'(bus4.tmds[39:30]), 40'(10'b1000000000));
      drive(3'd0, {3{8'hFF}}, 6'd0, 12'd0);
      step();
      chk("hop_b", 40'(bus.tmds), 40'({3{10'b0011111111}}));
      chk("hop_b_disp", 40'(bus.disp), 40'(d3(-2, -2, -2)));
      drive(3'd1, {3{8'hFF}}, 6'd0, 12'd0);
      step();
      chk("hop_ctrl", 40'(bus.tmds), 40'({3{CTRL00}}));
      chk("hop_ctrl_disp", 40'(bus.disp), 40'(d3(0, 0, 0)));
      step();
      chk("hop_restart", 40'(bus.tmds), 40'({3{10'b1000000000}}));
      chk("hop_restart_disp", 40'(bus.disp), 40'(d3(-8, -8, -8)));
      chk("hop_restart_lane3", 40'(bus4.disp[19:15]), 40'(5'b11000));

      drive(3'd2, 24'd0, 6'd0, 12'd0);
      step();
      step();
      chk("vid_gb", 40'(bus.tmds), 40'({GB_A, GB_B, GB_A}));
      chk("vid_gb_disp", 40'(bus.disp), 40'(d3(0, 0, 0)));
      chk("vid_gb_lane3", 40'(bus4.tmds[39:30]), 40'(GB_A));

      drive(3'd3, 24'd0, {2'b01, 2'b11, 2'b10}, 12'd0);
      step();
      step();
      chk("di_gb", 40'(bus.tmds), 40'({GB_B, GB_B, 10'b0101100011}));
      chk("di_gb_lane3", 40'(bus4.tmds[39:30]), 40'(10'b0101100011));

      for (int i = 0; i < 16; i++) begin
         drive(3'd4, 24'd0, 6'd0, {4'(i + 2), 4'(i + 1), 4'(i)});
         step();
         step();
         chk($sformatf("terc4_%0d", i), 40'(bus.tmds),
             40'({TERC[(i + 2) % 16], TERC[(i + 1) % 16], TERC[i]}));
         chk($sformatf("terc4_disp_%0d", i), 40'(bus.disp), 40'(d3(0, 0, 0)));
      end

      drive(3'd7, 24'd0, {3{2'b11}}, 12'd0);
      step();
      step();
      chk("mode7_ctrl", 40'(bus.tmds), 40'({3{CTRL11}}));

      drive(3'd1, 24'd0, 6'd0, 12'd0);
      step();
      step();
      chk("pre_rst_vid", 40'(bus.tmds), 40'({3{10'b0100000000}}));
      rst_n = 1'b0;
      step();
      chk("mid_rst", 40'(bus.tmds), 40'({3{CTRL00}}));
      chk("mid_rst_disp", 40'(bus.disp), 40'(d3(0, 0, 0)));
      rst_n = 1'b1;
      step();
      chk("post_rst_ctrl", 40'(bus.tmds), 40'({3{CTRL00}}));
      step();
      chk("post_rst_vid", 40'(bus.tmds), 40'({3{10'b0100000000}}));
      chk("post_rst_disp", 40'(bus.disp), 40'(d3(-8, -8, -8)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
